// File: rtl/sobel_seq_pkg.sv
// Shared types and constants for the Sobel tile sequencer.
package sobel_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWait,
    StLoad,
    StResult,
    StRdWait,
    StStore,
    StNext,
    StDone
  } seq_state_e;

  localparam logic [2:0] SB_ADDR_ROW0   = 3'd0;
  localparam logic [2:0] SB_ADDR_ROW1   = 3'd1;
  localparam logic [2:0] SB_ADDR_ROW2   = 3'd2;
  localparam logic [2:0] SB_ADDR_ROW3   = 3'd3;
  localparam logic [2:0] SB_ADDR_RESULT = 3'd4;

  localparam logic [3:0] SB_BE_ALL = 4'b1111;

endpackage

// File: rtl/sobel_seq_row_align.sv
// Half-word funnel: builds one 4-pixel tile row from one or two memory words.
module sobel_seq_row_align (
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic        odd_i,
  output logic [31:0] row_o
);

  // Only the upper half of the second word contributes to an odd-column row.
  logic unused_w1_lo;
  assign unused_w1_lo = ^w1_i[15:0];

  // Odd tiles start two pixels into a word: low half of w0, high half of w1.
  always_comb begin
    row_o = w0_i;
    if (odd_i) begin
      row_o = {w0_i[15:0], w1_i[31:16]};
    end
  end

endmodule

// File: rtl/sobel_tile_sequencer.sv
// Walks an image in overlapping 4x4 tiles (stride 2), feeds each tile to the Sobel
// slave and stores the packed result in raster tile order.
// Optional busy-cycle counter enabled by defining SOBEL_SEQ_PERF_EN.
module sobel_tile_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  img_w_i,
  input  logic [DIM_W-1:0]  img_h_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       perf_cycles_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rdvalid_i,
  input  logic              mem_waitrequest_i,
  output logic              sb_cs_o,
  output logic              sb_read_o,
  output logic              sb_write_o,
  output logic [2:0]        sb_addr_o,
  output logic [3:0]        sb_byteenable_o,
  output logic [31:0]       sb_wdata_o,
  input  logic [31:0]       sb_rdata_i
);

  seq_state_e        state_q;
  logic              busy_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_read_q, mem_write_q;
  logic [31:0]       mem_wdata_q;
  logic              sb_cs_q, sb_read_q, sb_write_q;
  logic [2:0]        sb_addr_q;
  logic [31:0]       sb_wdata_q;
  logic [ADDR_W-1:0] src_q, dst_q, stride_q;
  logic [DIM_W-1:0]  ntx_q, nty_q, tx_q, ty_q;
  logic [1:0]        r_q;
  logic              half_q;
  logic [31:0]       w0_q;

  logic              dims_ok, word_in, last_tx, last_ty;
  logic [31:0]       align_w0, aligned_row;
  logic [ADDR_W-1:0] store_addr;

  // Word address of row r of tile (tx, ty); wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [DIM_W-1:0] tx,
                                                 input logic [DIM_W-1:0] ty,
                                                 input logic [1:0]       r);
    logic [ADDR_W-1:0] line;
    line = ADDR_W'({ty, 1'b0}) + ADDR_W'(r);
    return src_q + line * stride_q + ADDR_W'(tx >> 1);
  endfunction

  assign dims_ok = (img_w_i >= DIM_W'(4)) && (img_w_i[1:0] == 2'b00) &&
                   (img_h_i >= DIM_W'(4)) && !img_h_i[0];
  // A read word can land in the same cycle the request is accepted.
  assign word_in = mem_rdvalid_i &&
                   ((state_q == StWait) || ((state_q == StFetch) && !mem_waitrequest_i));
  assign last_tx    = (tx_q == ntx_q - DIM_W'(1));
  assign last_ty    = (ty_q == nty_q - DIM_W'(1));
  assign store_addr = dst_q + ADDR_W'(ty_q) * ADDR_W'(ntx_q) + ADDR_W'(tx_q);
  assign align_w0   = half_q ? w0_q : mem_rdata_i;

  sobel_seq_row_align u_row_align (
    .w0_i  (align_w0),
    .w1_i  (mem_rdata_i),
    .odd_i (tx_q[0]),
    .row_o (aligned_row)
  );

  // Sequencer FSM; every bus strobe is registered and set on the transition into its state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      sb_cs_q     <= 1'b0;
      sb_read_q   <= 1'b0;
      sb_write_q  <= 1'b0;
      sb_addr_q   <= '0;
      sb_wdata_q  <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      stride_q    <= '0;
      ntx_q       <= '0;
      nty_q       <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      r_q         <= '0;
      half_q      <= 1'b0;
      w0_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (dims_ok) begin
              src_q      <= src_base_i;
              dst_q      <= dst_base_i;
              stride_q   <= ADDR_W'(img_w_i >> 2);
              ntx_q      <= (img_w_i >> 1) - DIM_W'(1);
              nty_q      <= (img_h_i >> 1) - DIM_W'(1);
              tx_q       <= '0;
              ty_q       <= '0;
              r_q        <= '0;
              half_q     <= 1'b0;
              busy_q     <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= src_base_i;
              state_q    <= StFetch;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StFetch, StWait: begin
          if ((state_q == StFetch) && !mem_waitrequest_i) begin
            mem_read_q <= 1'b0;
            state_q    <= StWait;
          end
          if (word_in) begin
            if (tx_q[0] && !half_q) begin
              w0_q       <= mem_rdata_i;
              half_q     <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
              state_q    <= StFetch;
            end else begin
              half_q     <= 1'b0;
              sb_cs_q    <= 1'b1;
              sb_write_q <= 1'b1;
              sb_addr_q  <= SB_ADDR_ROW0 + 3'(r_q);
              sb_wdata_q <= aligned_row;
              state_q    <= StLoad;
            end
          end
        end
        StLoad: begin
          sb_cs_q    <= 1'b0;
          sb_write_q <= 1'b0;
          if ({1'b0, r_q} == SB_ADDR_ROW3) begin
            r_q       <= '0;
            sb_cs_q   <= 1'b1;
            sb_read_q <= 1'b1;
            sb_addr_q <= SB_ADDR_RESULT;
            state_q   <= StResult;
          end else begin
            r_q        <= r_q + 2'd1;
            mem_read_q <= 1'b1;
            mem_addr_q <= row_addr(tx_q, ty_q, r_q + 2'd1);
            state_q    <= StFetch;
          end
        end
        StResult: begin
          sb_cs_q   <= 1'b0;
          sb_read_q <= 1'b0;
          state_q   <= StRdWait;
        end
        StRdWait: begin
          mem_wdata_q <= sb_rdata_i;
          mem_write_q <= 1'b1;
          mem_addr_q  <= store_addr;
          state_q     <= StStore;
        end
        StStore: begin
          if (!mem_waitrequest_i) begin
            mem_write_q <= 1'b0;
            state_q     <= StNext;
          end
        end
        StNext: begin
          if (last_tx) begin
            tx_q <= '0;
            if (last_ty) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              state_q <= StDone;
            end else begin
              ty_q       <= ty_q + DIM_W'(1);
              mem_read_q <= 1'b1;
              mem_addr_q <= row_addr('0, ty_q + DIM_W'(1), 2'd0);
              state_q    <= StFetch;
            end
          end else begin
            tx_q       <= tx_q + DIM_W'(1);
            mem_read_q <= 1'b1;
            mem_addr_q <= row_addr(tx_q + DIM_W'(1), ty_q, 2'd0);
            state_q    <= StFetch;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SOBEL_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter; any start seen in idle restarts it, it holds after done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      perf_q <= '0;
    end else if (busy_q) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign sb_cs_o         = sb_cs_q;
  assign sb_read_o       = sb_read_q;
  assign sb_write_o      = sb_write_q;
  assign sb_addr_o       = sb_addr_q;
  assign sb_byteenable_o = sb_write_q ? SB_BE_ALL : 4'b0000;
  assign sb_wdata_o      = sb_wdata_q;

endmodule

// File: tb/tb_sobel_tile_sequencer.sv
// Directed bench for sobel_tile_sequencer with a memory model and a Sobel slave model.
`timescale 1ns/1ps
module tb_sobel_tile_sequencer;

  logic        clk;
  logic        rst, start;
  logic [11:0] img_w, img_h;
  logic [15:0] src_base, dst_base;
  logic        busy, done, err;
  logic [31:0] perf_cycles;
  logic [15:0] mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rdvalid, mem_waitrequest;
  logic        sb_cs, sb_read, sb_write;
  logic [2:0]  sb_addr;
  logic [3:0]  sb_byteenable;
  logic [31:0] sb_wdata, sb_rdata;

  sobel_tile_sequencer #(.ADDR_W(16), .DIM_W(12)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .img_w_i           (img_w),
    .img_h_i           (img_h),
    .src_base_i        (src_base),
    .dst_base_i        (dst_base),
    .busy_o            (busy),
    .done_o            (done),
    .err_o             (err),
    .perf_cycles_o     (perf_cycles),
    .mem_addr_o        (mem_addr),
    .mem_read_o        (mem_read),
    .mem_write_o       (mem_write),
    .mem_wdata_o       (mem_wdata),
    .mem_rdata_i       (mem_rdata),
    .mem_rdvalid_i     (mem_rdvalid),
    .mem_waitrequest_i (mem_waitrequest),
    .sb_cs_o           (sb_cs),
    .sb_read_o         (sb_read),
    .sb_write_o        (sb_write),
    .sb_addr_o         (sb_addr),
    .sb_byteenable_o   (sb_byteenable),
    .sb_wdata_o        (sb_wdata),
    .sb_rdata_i        (sb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: wait_mode stalls every request 3 cycles and returns read data a cycle
  // after acceptance; otherwise data comes back in the acceptance cycle.
  logic [31:0] mem [0:1023];
  logic        wait_mode, clr;
  int          wcnt, stall_cnt, rd_cnt, sb_rd_cnt, done_cnt, be_bad, hold_viol;
  logic        rv_q, rd_held, wr_held;
  logic [31:0] rd_q, held_data, res_base;
  logic [15:0] held_addr;
  logic [15:0] mw_addr[$];
  logic [31:0] mw_data[$];
  logic [2:0]  sbw_addr[$];
  logic [31:0] sbw_data[$];
  logic [31:0] ref_data[6];

  assign mem_waitrequest = wait_mode && (mem_read || mem_write) && (wcnt < 3);
  assign mem_rdvalid     = wait_mode ? rv_q : (mem_read && !mem_waitrequest);
  assign mem_rdata       = wait_mode ? rd_q : mem[mem_addr[9:0]];

  initial begin
    wcnt = 0; rv_q = 1'b0; rd_q = '0; sb_rdata = '0;
    rd_held = 1'b0; wr_held = 1'b0; held_addr = '0; held_data = '0;
  end

  always @(posedge clk) begin
    if ((mem_read || mem_write) && mem_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
    rv_q <= mem_read && !mem_waitrequest;
    rd_q <= mem[mem_addr[9:0]];
    rd_held   <= mem_read && mem_waitrequest;
    wr_held   <= mem_write && mem_waitrequest;
    held_addr <= mem_addr;
    held_data <= mem_wdata;
    if (clr) begin
      stall_cnt <= 0; rd_cnt <= 0; sb_rd_cnt <= 0; done_cnt <= 0; be_bad <= 0; hold_viol <= 0;
      mw_addr.delete(); mw_data.delete(); sbw_addr.delete(); sbw_data.delete();
    end else begin
      if ((mem_read || mem_write) && mem_waitrequest) stall_cnt <= stall_cnt + 1;
      if (mem_read && !mem_waitrequest) rd_cnt <= rd_cnt + 1;
      if (mem_write && !mem_waitrequest) begin
        mw_addr.push_back(mem_addr);
        mw_data.push_back(mem_wdata);
      end
      if (sb_cs && sb_write) begin
        sbw_addr.push_back(sb_addr);
        sbw_data.push_back(sb_wdata);
        if (sb_byteenable != 4'hF) be_bad <= be_bad + 1;
      end
      if (sb_cs && sb_read) begin
        sb_rdata  <= res_base + 32'(sb_rd_cnt);
        sb_rd_cnt <= sb_rd_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (rd_held && (!mem_read || mem_addr != held_addr)) hold_viol <= hold_viol + 1;
      if (wr_held && (!mem_write || mem_addr != held_addr || mem_wdata != held_data))
        hold_viol <= hold_viol + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse_start(input int w, input int h, input logic [15:0] src,
                             input logic [15:0] dst, input logic [31:0] rbase);
    res_base = rbase;
    clear_sb();
    img_w = 12'(w); img_h = 12'(h); src_base = src; dst_base = dst;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_image(input int w, input int h, input logic [15:0] src,
                           input logic [15:0] dst, input logic [31:0] rbase, input int budget,
                           output logic got_done, output logic got_err, output int cycles);
    pulse_start(w, h, src, dst, rbase);
    got_done = 1'b0; got_err = 1'b0; cycles = 0;
    while (!got_done && cycles < budget) begin
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  logic gd, ge;
  int   cyc, bad;

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; wait_mode = 1'b0; res_base = '0;
    img_w = '0; img_h = '0; src_base = '0; dst_base = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[16'h100] = 32'h01020304; mem[16'h101] = 32'h05060708;
    mem[16'h102] = 32'h090A0B0C; mem[16'h103] = 32'h0D0E0F10;
    mem[16'h300] = 32'h00112233; mem[16'h301] = 32'h44556677;
    mem[16'h302] = 32'h8899AABB; mem[16'h303] = 32'hCCDDEEFF;
    mem[16'h304] = 32'h01234567; mem[16'h305] = 32'h89ABCDEF;
    mem[16'h306] = 32'hFEDCBA98; mem[16'h307] = 32'h76543210;
    mem[16'h308] = 32'h0F1E2D3C; mem[16'h309] = 32'h4B5A6978;
    mem[16'h30A] = 32'h8796A5B4; mem[16'h30B] = 32'hC3D2E1F0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy_done_err", {busy, done, err}, 3'b000);
    check_eq("rst_mem_strobes", {mem_read, mem_write}, 2'b00);
    check_eq("rst_sb_strobes", {sb_cs, sb_read, sb_write}, 3'b000);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_perf", perf_cycles, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4x4 image: single tile
    run_image(4, 4, 16'h100, 16'h200, 32'hA1B2C3D4, 200, gd, ge, cyc);
    check_eq("t44_done", gd, 1'b1);
    check_eq("t44_err", ge, 1'b0);
    check_eq("t44_busy_after", busy, 1'b0);
    check_eq("t44_sbw_count", sbw_data.size(), 4);
    check_eq("t44_sbw0", sbw_data[0], 32'h01020304);
    check_eq("t44_sbw1", sbw_data[1], 32'h05060708);
    check_eq("t44_sbw2", sbw_data[2], 32'h090A0B0C);
    check_eq("t44_sbw3", sbw_data[3], 32'h0D0E0F10);
    check_eq("t44_sbw_addrs", {sbw_addr[0], sbw_addr[1], sbw_addr[2], sbw_addr[3]},
             12'b000_001_010_011);
    check_eq("t44_sb_reads", sb_rd_cnt, 1);
    check_eq("t44_mw_count", mw_data.size(), 1);
    check_eq("t44_mw_addr", mw_addr[0], 16'h0200);
    check_eq("t44_mw_data", mw_data[0], 32'hA1B2C3D4);
    check_eq("t44_mem_reads", rd_cnt, 4);
    check_eq("t44_byteenable", be_bad, 0);
`ifdef SOBEL_SEQ_PERF_EN
    check_eq("t44_perf", perf_cycles, 32'd12);
`else
    check_eq("t44_perf", perf_cycles, 32'd0);
`endif

    // 8x6 image, zero wait: 3x2 tiles
    @(negedge clk);
    run_image(8, 6, 16'h300, 16'h380, 32'h5EED0000, 500, gd, ge, cyc);
    check_eq("t86_done", gd, 1'b1);
    check_eq("t86_err", ge, 1'b0);
    check_eq("t86_sbw_count", sbw_data.size(), 24);
    check_eq("t86_t0_r0", sbw_data[0], 32'h00112233);
    check_eq("t86_t1_r0", sbw_data[4], 32'h22334455);
    check_eq("t86_t1_r1", sbw_data[5], 32'hAABBCCDD);
    check_eq("t86_t2_r0", sbw_data[8], 32'h44556677);
    check_eq("t86_t3_r0", sbw_data[12], 32'h01234567);
    check_eq("t86_t4_r0", sbw_data[16], 32'h456789AB);
    check_eq("t86_t4_r3", sbw_data[19], 32'hA5B4C3D2);
    check_eq("t86_t5_r1", sbw_data[21], 32'h76543210);
    bad = 0;
    for (int k = 0; k < 24; k++) if (sbw_addr[k] != 3'(k % 4)) bad++;
    check_eq("t86_sbw_addrs", bad, 0);
    check_eq("t86_mem_reads", rd_cnt, 32);
    check_eq("t86_mw_count", mw_data.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("t86_mw_addr%0d", k), mw_addr[k], 16'h0380 + 16'(k));
      check_eq($sformatf("t86_mw_data%0d", k), mw_data[k], 32'h5EED0000 + 32'(k));
      ref_data[k] = 32'h5EED0000 + 32'(k);
    end
`ifdef SOBEL_SEQ_PERF_EN
    check_eq("t86_perf", perf_cycles, 32'd80);
`else
    check_eq("t86_perf", perf_cycles, 32'd0);
`endif

    // Same image with 3 wait states on every request
    @(negedge clk);
    wait_mode = 1'b1;
    run_image(8, 6, 16'h300, 16'h380, 32'h5EED0000, 3000, gd, ge, cyc);
    check_eq("tws_done", gd, 1'b1);
    check_eq("tws_err", ge, 1'b0);
    check_eq("tws_stalls_seen", stall_cnt > 0, 1'b1);
    check_eq("tws_hold_viol", hold_viol, 0);
    check_eq("tws_sbw_count", sbw_data.size(), 24);
    check_eq("tws_t4_r0", sbw_data[16], 32'h456789AB);
    check_eq("tws_mw_count", mw_data.size(), 6);
    bad = 0;
    for (int k = 0; k < 6; k++)
      if (mw_data[k] != ref_data[k] || mw_addr[k] != 16'h0380 + 16'(k)) bad++;
    check_eq("tws_mw_match", bad, 0);
    wait_mode = 1'b0;

    // Rejected dimensions
    @(negedge clk);
    run_image(6, 4, 16'h100, 16'h200, 32'h0, 20, gd, ge, cyc);
    check_eq("rej_w6_done", gd, 1'b1);
    check_eq("rej_w6_err", ge, 1'b1);
    check_eq("rej_w6_latency", cyc, 0);
    check_eq("rej_w6_busy", busy, 1'b0);
    check_eq("rej_w6_perf", perf_cycles, 32'd0);
    @(negedge clk);
    check_eq("rej_w6_no_bus", sbw_data.size() + mw_data.size() + rd_cnt + sb_rd_cnt, 0);
    run_image(8, 5, 16'h100, 16'h200, 32'h0, 20, gd, ge, cyc);
    check_eq("rej_h5_done", gd, 1'b1);
    check_eq("rej_h5_err", ge, 1'b1);
    check_eq("rej_h5_latency", cyc, 0);
    @(negedge clk);
    check_eq("rej_h5_no_bus", sbw_data.size() + mw_data.size() + rd_cnt + sb_rd_cnt, 0);

    // Reset during the store of tile 2
    pulse_start(8, 6, 16'h300, 16'h380, 32'h0);
    cyc = 0;
    while (!(mem_write && mw_data.size() == 2) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_mid_found_store", mem_write && mw_data.size() == 2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_strobes",
             {mem_read, mem_write, sb_cs, sb_read, sb_write, busy, done}, 7'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_mid_no_done", done_cnt, 0);
    run_image(4, 4, 16'h100, 16'h240, 32'hA1B2C3D4, 200, gd, ge, cyc);
    check_eq("rst_rerun_done", gd, 1'b1);
    check_eq("rst_rerun_err", ge, 1'b0);
    check_eq("rst_rerun_mw_addr", mw_addr[0], 16'h0240);
    check_eq("rst_rerun_mw_data", mw_data[0], 32'hA1B2C3D4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
